// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared state type, default sizing constants and busy edge helper
// for the I2C transaction sequencer.
package i2c_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int MAX_LEN_DEF = 8;
    localparam int TIMEOUT_DEF = 480000;
    function automatic logic [1:0] edge_det(input logic cur, input logic prev);
        return {cur & ~prev, ~cur & prev};
    endfunction
endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// i2c_txn_sequencer_if: client request/response signals plus the i2c_master control
// and status signals; master = sequencer side, slave = client/core side.
interface i2c_txn_sequencer_if #(parameter int LEN_W = 4);
    logic             req;
    logic [6:0]       dev_addr;
    logic [7:0]       reg_addr;
    logic             is_read;
    logic [LEN_W-1:0] len;
    logic [7:0]       wdata;
    logic             ready;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic             done;
    logic             err;
    logic             m_reset_n;
    logic             m_ena;
    logic [6:0]       m_addr;
    logic             m_rw;
    logic [7:0]       m_data_wr;
    logic             m_busy;
    logic [7:0]       m_data_rd;
    logic             m_ack_error;
    modport master (
        input  req, dev_addr, reg_addr, is_read, len, wdata, m_busy, m_data_rd, m_ack_error,
        output ready, rd_valid, rd_data, done, err, m_reset_n, m_ena, m_addr, m_rw, m_data_wr
    );
    modport slave (
        output req, dev_addr, reg_addr, is_read, len, wdata, m_busy, m_data_rd, m_ack_error,
        input  ready, rd_valid, rd_data, done, err, m_reset_n, m_ena, m_addr, m_rw, m_data_wr
    );
endinterface

// File: rtl/i2c_busy_edge.sv
// i2c_busy_edge: registers the core busy flag and counts its rising/falling edges,
// saturating at MAX_LEN+1; i_clr restarts both counts for a new transaction.
module i2c_busy_edge
    import i2c_seq_pkg::*;
#(
    parameter int LEN_W   = 4,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_busy,
    input  logic             i_clr,
    output logic             o_busy_q,
    output logic             o_rise,
    output logic             o_fall,
    output logic [LEN_W-1:0] o_rise_cnt,
    output logic [LEN_W-1:0] o_fall_cnt
);
    localparam logic [LEN_W-1:0] SAT = LEN_W'(MAX_LEN + 1);
    logic             r_busy_q;
    logic [LEN_W-1:0] r_rise_cnt, r_fall_cnt;
    assign {o_rise, o_fall} = edge_det(i_busy, r_busy_q);
    assign o_busy_q   = r_busy_q;
    assign o_rise_cnt = r_rise_cnt;
    assign o_fall_cnt = r_fall_cnt;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy_q   <= 1'b0;
            r_rise_cnt <= '0;
            r_fall_cnt <= '0;
        end else begin
            r_busy_q   <= i_busy;
            r_rise_cnt <= i_clr ? '0 : r_rise_cnt + LEN_W'(o_rise && r_rise_cnt != SAT);
            r_fall_cnt <= i_clr ? '0 : r_fall_cnt + LEN_W'(o_fall && r_fall_cnt != SAT);
        end
    end
endmodule

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: steps i2c_master through a register write or a repeated-start read.
// Define I2C_SEQ_TIMEOUT_EN to add the per-byte watchdog that resets a stuck core.
module i2c_txn_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int MAX_LEN        = MAX_LEN_DEF,
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input logic                 clk,
    input logic                 reset_n,
    i2c_txn_sequencer_if.master io_bus
);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    if (LEN_W < $clog2(MAX_LEN + 1) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("i2c_txn_sequencer: LEN_W too narrow for MAX_LEN or TIMEOUT_CYCLES < 1");
    end
    state_t           r_state, w_next;
    logic             r_is_read, r_ena, r_rw, r_rd_valid, r_sticky, r_mrst_n;
    logic [LEN_W-1:0] r_len, w_len, w_rise_cnt, w_fall_cnt;
    logic [6:0]       r_addr, w_addr_n;
    logic [7:0]       r_wdata, r_data_wr, r_rd_data, w_data_wr_n, w_rd_data_n;
    logic             w_busy_q, w_rise, w_fall, w_accept, w_nack, w_capture, w_stop;
    logic             w_drained, w_done, w_tmo, w_hold, w_ena_n, w_rw_n, w_sticky_n;
    i2c_busy_edge #(.LEN_W(LEN_W), .MAX_LEN(MAX_LEN)) u_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_busy     (io_bus.m_busy),
        .i_clr      (w_accept),
        .o_busy_q   (w_busy_q),
        .o_rise     (w_rise),
        .o_fall     (w_fall),
        .o_rise_cnt (w_rise_cnt),
        .o_fall_cnt (w_fall_cnt)
    );
    assign w_len     = (io_bus.len == '0) ? LEN_W'(1) : (io_bus.len > MAX_L) ? MAX_L : io_bus.len;
    assign w_accept  = r_state == IDLE && io_bus.req && !io_bus.m_busy && !w_hold;
    assign w_nack    = r_state != IDLE && w_fall && io_bus.m_ack_error;
    // fall 1 ends the pointer byte; falls 2..N+1 each deliver one read byte
    assign w_capture = r_state != IDLE && r_is_read && w_fall && !io_bus.m_ack_error && !r_sticky
                       && w_fall_cnt != '0 && w_fall_cnt <= r_len;
    assign w_stop    = r_state == RUN && w_rise && !w_nack
                       && w_rise_cnt == (r_is_read ? r_len : LEN_W'(1));
    assign w_drained = !io_bus.m_busy && !w_busy_q && (!r_is_read || r_sticky || w_fall_cnt > r_len);
    assign w_done    = (r_state == DRAIN && w_drained) || w_tmo;
`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;
    logic [1:0]    r_hold;
    assign w_tmo  = r_state != IDLE && r_tmo == '0;
    assign w_hold = r_hold != 2'd0;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tmo  <= TW'(TIMEOUT_CYCLES);
            r_hold <= 2'd0;
        end else begin
            r_tmo  <= (w_accept || w_rise || w_fall) ? TW'(TIMEOUT_CYCLES)
                    : (r_state != IDLE && r_tmo != '0) ? r_tmo - 1'b1 : r_tmo;
            r_hold <= w_tmo ? 2'd2 : r_hold - 2'(r_hold != 2'd0);
        end
    end
`else
    assign w_tmo  = 1'b0;
    assign w_hold = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_is_read  <= 1'b0;
            r_len      <= '0;
            r_wdata    <= '0;
            r_ena      <= 1'b0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_data_wr  <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_sticky   <= 1'b0;
            r_mrst_n   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ena      <= w_ena_n;
            r_rw       <= w_rw_n;
            r_addr     <= w_addr_n;
            r_data_wr  <= w_data_wr_n;
            r_rd_data  <= w_rd_data_n;
            r_rd_valid <= w_capture;
            r_sticky   <= w_sticky_n;
            r_mrst_n   <= 1'b1;
            if (w_accept) begin
                r_is_read <= io_bus.is_read;
                r_len     <= w_len;
                r_wdata   <= io_bus.wdata;
            end
        end
    end
    always_comb begin
        w_next = w_tmo ? IDLE
               : r_state == IDLE ? (w_accept ? RUN : IDLE)
               : r_state == RUN ? ((w_nack || w_stop) ? DRAIN : RUN)
               : (w_done ? IDLE : DRAIN);
    end
    // an error fall outranks any rise handled alongside it
    always_comb begin
        w_ena_n     = w_accept ? 1'b1 : (w_nack || w_stop || w_tmo) ? 1'b0 : r_ena;
        w_rw_n      = w_accept ? 1'b0
                    : (r_state == RUN && w_rise && !w_nack && r_is_read && w_rise_cnt == '0) ? 1'b1 : r_rw;
        w_addr_n    = w_accept ? io_bus.dev_addr : r_addr;
        w_data_wr_n = w_accept ? io_bus.reg_addr
                    : (r_state == RUN && w_rise && !w_nack && !r_is_read && w_rise_cnt == '0) ? r_wdata : r_data_wr;
        w_rd_data_n = w_capture ? io_bus.m_data_rd : r_rd_data;
        w_sticky_n  = w_accept ? 1'b0 : (w_nack || w_tmo) ? 1'b1 : r_sticky;
    end
    assign io_bus.ready     = r_state == IDLE;
    assign io_bus.rd_valid  = r_rd_valid;
    assign io_bus.rd_data   = r_rd_data;
    assign io_bus.done      = w_done;
    assign io_bus.err       = w_done && (r_sticky || w_tmo);
    assign io_bus.m_reset_n = r_mrst_n && !w_hold;
    assign io_bus.m_ena     = r_ena;
    assign io_bus.m_addr    = r_addr;
    assign io_bus.m_rw      = r_rw;
    assign io_bus.m_data_wr = r_data_wr;
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: scoreboard bench driving the sequencer against a behavioural
// i2c_master model (one busy high period per byte, ack_error reported on the falling busy).
`timescale 1ns/1ps
module tb_i2c_txn_sequencer;
    localparam int LEN_W = 4;
    localparam int BYTE  = 6;
`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 480000;
`endif
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    i2c_txn_sequencer_if #(.LEN_W(LEN_W)) bus ();
    i2c_txn_sequencer #(.MAX_LEN(8), .LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (bus.master)
    );
    int total = 0;
    int bad = 0;
    int n_done = 0;
    int n_rd = 0;
    int mrst_low = 0;
    logic [7:0] exp_rd[$];
    logic       exp_err[$];
    logic [7:0] rd_src[$];
    logic [8:0] log_q[$];
    int         mst = 0;
    int         mcnt = 0;
    int         byte_idx = 0;
    bit         nack_en = 0;
    bit         stuck = 0;
    logic       lat_rw;
    logic [7:0] lat_data;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic start_byte();
        lat_rw   = bus.m_rw;
        lat_data = bus.m_data_wr;
        log_q.push_back({lat_rw, lat_data});
        bus.m_busy = 1'b1;
        mcnt = 0;
        mst  = 1;
    endtask
    // core model: 0 idle, 1 byte in flight, 2 byte boundary, 3 stop condition
    initial begin
        forever begin
            @(negedge clk);
            if (!bus.m_reset_n) begin
                mst = 0;
                bus.m_busy = 1'b0;
                bus.m_ack_error = 1'b0;
            end else if (mst == 0) begin
                if (bus.m_ena) begin
                    bus.m_ack_error = 1'b0;
                    byte_idx = 0;
                    start_byte();
                end
            end else if (mst == 1) begin
                if (mcnt < BYTE || stuck) mcnt++;
                else begin
                    if (lat_rw && rd_src.size() > 0) bus.m_data_rd = rd_src.pop_front();
                    bus.m_ack_error = nack_en && byte_idx == 0;
                    bus.m_busy = 1'b0;
                    byte_idx++;
                    mst = 2;
                end
            end else if (mst == 2) begin
                if (bus.m_ena && !bus.m_ack_error) start_byte();
                else begin
                    mst = 3;
                    mcnt = 0;
                end
            end else begin
                mcnt++;
                if (mcnt >= 3) mst = 0;
            end
        end
    end
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && !bus.m_reset_n) mrst_low++;
            if (bus.rd_valid) begin
                n_rd++;
                check("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
                if (exp_rd.size() > 0) check("rd_data", 32'(bus.rd_data), 32'(exp_rd.pop_front()));
            end
            if (bus.done) begin
                n_done++;
                check("done_expected", 32'(exp_err.size() > 0), 32'd1);
                if (exp_err.size() > 0) check("err", 32'(bus.err), 32'(exp_err.pop_front()));
            end
        end
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    task automatic issue(input bit rd, input logic [6:0] dev, input logic [7:0] ra,
                         input logic [7:0] wd, input logic [LEN_W-1:0] ln);
        int t = 0;
        bus.req = 1'b1;
        bus.is_read = rd;
        bus.dev_addr = dev;
        bus.reg_addr = ra;
        bus.wdata = wd;
        bus.len = ln;
        do begin
            @(negedge clk);
            t++;
        end while (bus.ready && t < 50);
        bus.req = 1'b0;
        check("accepted", 32'(bus.ready), 32'd0);
    endtask
    task automatic wait_done(input int base);
        int t = 0;
        while (n_done == base && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", n_done, base + 1);
        @(negedge clk);
        check("ready_back", 32'(bus.ready), 32'd1);
    endtask
    task automatic load_rd(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            rd_src.push_back(base + 8'(i * 'h11));
            exp_rd.push_back(base + 8'(i * 'h11));
        end
    endtask
    task automatic read_txn(input string tag, input logic [LEN_W-1:0] ln, input int n, input logic [7:0] base);
        int b = n_done;
        int r = n_rd;
        log_q.delete();
        load_rd(n, base);
        exp_err.push_back(1'b0);
        issue(1'b1, 7'h50, 8'h00, 8'h00, ln);
        wait_done(b);
        check({tag, "_bytes"}, log_q.size(), n + 1);
        check({tag, "_ptr"}, 32'(log_q[0]), 32'h000);
        check({tag, "_rw1"}, 32'(log_q[1][8]), 32'd1);
        check({tag, "_nrd"}, n_rd - r, n);
    endtask
    initial begin
        int b;
        int r;
        int t;
        bus.req = 1'b0;
        bus.dev_addr = '0;
        bus.reg_addr = '0;
        bus.is_read = 1'b0;
        bus.len = '0;
        bus.wdata = '0;
        bus.m_busy = 1'b0;
        bus.m_data_rd = '0;
        bus.m_ack_error = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs", 32'({bus.m_ena, bus.m_rw, bus.m_addr, bus.m_data_wr, bus.rd_valid,
                               bus.rd_data, bus.done, bus.err, bus.m_reset_n}), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);
        check("mrst_release", 32'(bus.m_reset_n), 32'd1);
        b = n_done;
        r = n_rd;
        log_q.delete();
        exp_err.push_back(1'b0);
        issue(1'b0, 7'h25, 8'h03, 8'hA5, '0);
        check("wr_ena", 32'(bus.m_ena), 32'd1);
        check("wr_addr", 32'(bus.m_addr), 32'h25);
        check("wr_ptr", 32'(bus.m_data_wr), 32'h03);
        check("wr_rw", 32'(bus.m_rw), 32'd0);
        wait_done(b);
        check("wr_bytes", log_q.size(), 2);
        check("wr_byte0", 32'(log_q[0]), 32'h003);
        check("wr_byte1", 32'(log_q[1]), 32'h0A5);
        check("wr_ena_off", 32'(bus.m_ena), 32'd0);
        check("wr_nrd", n_rd - r, 0);
        read_txn("rd3", 4'd3, 3, 8'h11);
        read_txn("rd1", 4'd1, 1, 8'h5A);
        read_txn("rd0", 4'd0, 1, 8'h77);
        read_txn("rd15", 4'd15, 8, 8'h01);
        b = n_done;
        r = n_rd;
        log_q.delete();
        nack_en = 1'b1;
        exp_err.push_back(1'b1);
        issue(1'b1, 7'h50, 8'h00, 8'h00, 4'd4);
        wait_done(b);
        nack_en = 1'b0;
        check("nack_bytes", log_q.size(), 1);
        check("nack_nrd", n_rd - r, 0);
        check("nack_ena", 32'(bus.m_ena), 32'd0);
        b = n_done;
        r = n_rd;
        log_q.delete();
        issue(1'b1, 7'h50, 8'h10, 8'h00, 4'd4);
        t = 0;
        while (log_q.size() < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("mid_rise2", 32'(log_q.size() >= 2), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_outs", 32'({bus.m_ena, bus.m_rw, bus.m_addr, bus.m_data_wr, bus.rd_valid,
                                   bus.rd_data, bus.done, bus.err, bus.m_reset_n}), 32'd0);
        check("mid_no_done", n_done, b);
        check("mid_no_rd", n_rd, r);
        reset_n = 1'b1;
        @(negedge clk);
        rd_src.delete();
        b = n_done;
        log_q.delete();
        exp_err.push_back(1'b0);
        issue(1'b0, 7'h25, 8'h04, 8'h3C, '0);
        wait_done(b);
        check("post_bytes", log_q.size(), 2);
        check("post_data", 32'(log_q[1]), 32'h03C);
`ifdef I2C_SEQ_TIMEOUT_EN
        b = n_done;
        stuck = 1'b1;
        mrst_low = 0;
        exp_err.push_back(1'b1);
        issue(1'b0, 7'h25, 8'h05, 8'h66, '0);
        wait_done(b);
        repeat (4) @(negedge clk);
        stuck = 1'b0;
        check("tmo_mrst_low", mrst_low, 2);
        check("tmo_ready", 32'(bus.ready), 32'd1);
`endif
        repeat (5) @(negedge clk);
        check("exp_rd_left", exp_rd.size(), 0);
        check("exp_err_left", exp_err.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_txn_sequencer.md
Name: i2c_txn_sequencer

Overview:
Sequences the shared i2c_master core through complete register transactions on behalf of one client: a register write (pointer + 1 data byte), or a register read (pointer write, repeated-start read of 1..MAX_LEN bytes). It owns the master's ena/rw/addr/data_wr inputs and tracks the busy edges that hand off each byte. It replaces the hand-coded busy-edge case ladders in top-level designs.

Parameters:
MAX_LEN, 8, maximum bytes per read; len values above this are clamped to it.
LEN_W, 4, width of len and byte counters; must be at least clog2(MAX_LEN+1).
TIMEOUT_CYCLES, 480000, clk cycles a single byte phase may take before abort (10 ms at 48 MHz); used only with the optional feature.

Ports:
clk  in  1  system clock (48 MHz).
reset_n  in  1  synchronous, active-low reset.
req  in  1  start a transaction; sampled only in IDLE.
dev_addr  in  7  7-bit device address.
reg_addr  in  8  register pointer byte.
is_read  in  1  1 = read transaction, 0 = write.
len  in  LEN_W  read byte count, 1..MAX_LEN; 0 is treated as 1; ignored for writes.
wdata  in  8  data byte for writes.
ready  out  1  high in IDLE only.
rd_valid  out  1  1-cycle strobe per received byte.
rd_data  out  8  received byte, valid with rd_valid.
done  out  1  1-cycle strobe at transaction end.
err  out  1  valid with done: NACK or timeout occurred.
m_reset_n  out  1  to i2c_master reset_n.
m_ena  out  1  to i2c_master ena.
m_addr  out  7  to i2c_master addr.
m_rw  out  1  to i2c_master rw.
m_data_wr  out  8  to i2c_master data_wr.
m_busy  in  1  from i2c_master busy.
m_data_rd  in  8  from i2c_master data_rd.
m_ack_error  in  1  from i2c_master ack_error.

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE. Outputs: m_ena=0, m_rw=0, m_addr=0, m_data_wr=0, rd_valid=0, rd_data=0, done=0, err=0, m_reset_n=0. m_reset_n goes high on the first clk edge after reset is released. Reset mid-transaction abandons it with no done pulse.
- busy_q is a registered copy of m_busy. rise = m_busy & ~busy_q. fall = ~m_busy & busy_q.
- IDLE: ready=1. If req=1 and m_busy=0: latch all request fields. Drive m_ena=1, m_rw=0, m_addr=dev_addr, m_data_wr=reg_addr. Clear rise_cnt, fall_cnt and the sticky error. Go to RUN on the next cycle.
- IDLE with req=1 and m_busy=1 (core still finishing): wait in IDLE; do not accept.
- RUN, write, on each rise:
  - rise 1: m_data_wr=wdata.
  - rise 2: m_ena=0, go to DRAIN.
- RUN, read with N bytes, on each rise:
  - rise 1: m_rw=1 (repeated start).
  - rise k+1 for k=1..N: if k==N, m_ena=0 and go to DRAIN; otherwise hold m_ena=1.
- Captures, read only, in RUN and DRAIN: on fall number f, for f=2..N+1, rd_data<=m_data_rd and rd_valid=1 for exactly one cycle. Fall 1 (the pointer byte) never produces rd_valid. Exactly N strobes per error-free read.
- NACK: on any fall with m_ack_error=1, set the sticky error, force m_ena=0 and go to DRAIN. Suppress any further rd_valid.
- DRAIN: wait until m_busy=0 and busy_q=0. Read transactions also require that all N captures are complete or the error is set. Then pulse done=1 for one cycle with err=sticky error, and return to IDLE. ready rises the cycle after done.
- Simultaneous rise and fall in the same cycle cannot occur. If a rise and an ack_error fall are processed in the same state, the error takes priority over the rise and the rise is ignored.
- Counters saturate at MAX_LEN+1; they never wrap.

Optional Feature:
Macro I2C_SEQ_TIMEOUT_EN.
- Defined:
  - A down-counter reloads with TIMEOUT_CYCLES on every rise/fall and when leaving IDLE; it decrements in RUN and DRAIN.
  - When it reaches 0: drive m_reset_n=0 for 2 cycles, set the sticky error, pulse done with err=1, and return to IDLE.
- Undefined: no counter. The block waits indefinitely on a stuck busy.

Decomposition:
- Package i2c_seq_pkg holds the state enum (IDLE, RUN, DRAIN), the default MAX_LEN/TIMEOUT constants, and an edge-detect helper function.
- One natural sub-module, i2c_busy_edge: busy_q register, rise/fall outputs, and saturating rise/fall counters.
- The master core is instantiated by the parent, not inside this block.

Test Plan:
- Write: dev 0x25, reg 0x03, data 0xA5, slave model ACKs. Expect: m_data_wr is 0x03 then 0xA5, m_ena falls after rise 2, done=1 and err=0, no rd_valid.
- Read len=3 from reg 0x00, model returns 0x11, 0x22, 0x33. Expect: m_rw goes 1 after rise 1; three rd_valid strobes carrying 0x11, 0x22, 0x33 in order; done with err=0.
- Read len=1. Expect: m_ena drops at rise 2, exactly one rd_valid, then done.
- Address NACK (m_ack_error=1 on fall 1) during a read of len 4. Expect: m_ena=0, zero rd_valid, done with err=1, ready returns to 1.
- Assert reset_n=0 mid-read after rise 2. Expect: all outputs return to their reset values, no done pulse, m_reset_n=0. A new req after release completes normally.
- With I2C_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, hold m_busy=1 forever. Expect: m_reset_n low for 2 cycles about 100 cycles after the last edge, done with err=1, back to IDLE.
